// File: rtl/banner_column_reader.sv
// Reader for the banner row ROMs: fetches a WINDOW-row slice starting at a
// scroll base and hands each row downstream over a valid/ready handshake.
module banner_column_reader #(
    parameter int unsigned ROW_WIDTH = 57,
    parameter int unsigned NUM_ROWS  = 129,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned WINDOW    = 32,
    parameter int unsigned ROM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 scroll_en,
    output logic [ADDR_W-1:0]    rom_address,
    input  logic [ROW_WIDTH-1:0] rom_data,
    output logic [ROW_WIDTH-1:0] col_data,
    output logic [ADDR_W-1:0]    col_index,
    output logic                 col_valid,
    input  logic                 col_ready,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned CNT_W = $clog2(ROM_LAT + 2);
    localparam int unsigned SUM_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [ADDR_W-1:0]    base_q;
    logic [ADDR_W-1:0]    idx_q;
    logic [CNT_W-1:0]     wait_cnt_q;
    logic [ADDR_W-1:0]    rom_address_q;
    logic [ROW_WIDTH-1:0] col_data_q;
    logic [ADDR_W-1:0]    col_index_q;
    logic                 col_valid_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic [SUM_W-1:0]     addr_sum_d;
    logic [ADDR_W-1:0]    addr_wrap_d;

    // (base + idx) mod NUM_ROWS; both operands are below NUM_ROWS so one subtract suffices
    always_comb begin
        addr_sum_d  = SUM_W'(base_q) + SUM_W'(idx_q);
        addr_wrap_d = ADDR_W'(addr_sum_d);
        if (addr_sum_d >= SUM_W'(NUM_ROWS)) begin
            addr_wrap_d = ADDR_W'(addr_sum_d - SUM_W'(NUM_ROWS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            idx_q         <= '0;
            wait_cnt_q    <= '0;
            rom_address_q <= '0;
            col_data_q    <= '0;
            col_index_q   <= '0;
            col_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rom_address_q <= addr_wrap_d;
                    wait_cnt_q    <= '0;
                    state_q       <= S_WAIT;
                end
                // One cycle for the ROM's address register, ROM_LAT more for data
                S_WAIT: begin
                    if (wait_cnt_q == CNT_W'(ROM_LAT)) begin
                        col_data_q  <= rom_data;
                        col_index_q <= idx_q;
                        col_valid_q <= 1'b1;
                        wait_cnt_q  <= '0;
                        state_q     <= S_PRESENT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (col_ready) begin
                        col_valid_q <= 1'b0;
                        if (idx_q == ADDR_W'(WINDOW - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    if (scroll_en) begin
                        base_q <= (base_q == ADDR_W'(NUM_ROWS - 1)) ? '0 : base_q + ADDR_W'(1);
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_address = rom_address_q;
    assign col_data    = col_data_q;
    assign col_index   = col_index_q;
    assign col_valid   = col_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_banner_column_reader.sv
// Bench for banner_column_reader: registered-address ROM model plus a
// scoreboard that predicts each frame from the scroll base and ROM contents.
module tb_banner_column_reader;

    localparam int ROW_WIDTH = 57;
    localparam int NUM_ROWS  = 129;
    localparam int ADDR_W    = 8;
    localparam int WINDOW    = 32;
    localparam int ROM_LAT   = 1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 scroll_en;
    logic [ADDR_W-1:0]    rom_address;
    logic [ROW_WIDTH-1:0] rom_data;
    logic [ROW_WIDTH-1:0] col_data;
    logic [ADDR_W-1:0]    col_index;
    logic                 col_valid;
    logic                 col_ready;
    logic                 busy;
    logic                 frame_done;

    banner_column_reader #(
        .ROW_WIDTH(ROW_WIDTH),
        .NUM_ROWS (NUM_ROWS),
        .ADDR_W   (ADDR_W),
        .WINDOW   (WINDOW),
        .ROM_LAT  (ROM_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .scroll_en  (scroll_en),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .col_data   (col_data),
        .col_index  (col_index),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [ROW_WIDTH-1:0] rom_mem [NUM_ROWS];
    always @(posedge clk) begin
        rom_data <= (int'(rom_address) < NUM_ROWS) ? rom_mem[rom_address] : '0;
    end

    int errors;
    int checks;
    int base_model;
    int done_pulses;
    logic [ROW_WIDTH-1:0] got_data[$];
    int got_idx[$];
    int got_addr[$];
    int rise_cyc[$];
    int chg_cyc[$];

    // Runs one frame and scores every accepted beat against rom[(base+i) mod NUM_ROWS]
    task automatic run_frame(input int ready_pct, input int stall_idx, input int restart_idx,
                             input bit scroll_final, input bit scroll_random);
        int cyc, after, stall_cnt, exp_addr;
        bit last_seen, restarted;
        logic [ADDR_W-1:0] prev_addr, held_i, held_a;
        logic prev_valid;
        logic [ROW_WIDTH-1:0] held_d;
        got_data.delete(); got_idx.delete(); got_addr.delete();
        rise_cyc.delete(); chg_cyc.delete();
        done_pulses = 0;
        @(negedge clk);
        scroll_en = scroll_random ? 1'($urandom_range(1)) : scroll_final;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev_addr = rom_address; prev_valid = col_valid;
        cyc = 0; after = -1; stall_cnt = 0; last_seen = 0; restarted = 0;
        held_d = '0; held_i = '0; held_a = '0;
        while (1'b1) begin
            if (rom_address != prev_addr) chg_cyc.push_back(cyc);
            if (col_valid && !prev_valid) rise_cyc.push_back(cyc);
            prev_addr = rom_address; prev_valid = col_valid;
            if (frame_done) done_pulses++;
            if (col_valid && int'(col_index) == WINDOW - 1) last_seen = 1;
            scroll_en = (scroll_random && !last_seen) ? 1'($urandom_range(1)) : scroll_final;
            if (col_valid && int'(col_index) == stall_idx) begin
                if (stall_cnt == 0) begin
                    held_d = col_data; held_i = col_index; held_a = rom_address;
                end else begin
                    checks += 3;
                    if (col_data !== held_d) begin
                        errors++; $display("FAIL stall_data: got %h want %h", col_data, held_d);
                    end
                    if (col_index !== held_i) begin
                        errors++; $display("FAIL stall_index: got %0d want %0d", col_index, held_i);
                    end
                    if (rom_address !== held_a) begin
                        errors++; $display("FAIL stall_addr: got %0d want %0d", rom_address, held_a);
                    end
                end
                col_ready = (stall_cnt >= 5);
                stall_cnt++;
            end else begin
                col_ready = ($urandom_range(99) < ready_pct);
            end
            if (col_valid && col_ready) begin
                got_data.push_back(col_data);
                got_idx.push_back(int'(col_index));
                got_addr.push_back(int'(rom_address));
            end
            start = (restart_idx >= 0 && col_valid && int'(col_index) == restart_idx && !restarted);
            if (start) restarted = 1;
            if (done_pulses > 0 && after < 0) after = 0;
            if (after >= 0) after++;
            if (after > 10) break;
            if (cyc > 4000) begin
                checks++; errors++;
                $display("FAIL frame_timeout: got no frame_done after %0d cycles want done", cyc);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks += 3;
        if (got_data.size() !== WINDOW) begin
            errors++; $display("FAIL beat_count: got %0d want %0d", got_data.size(), WINDOW);
        end
        if (done_pulses !== 1) begin
            errors++; $display("FAIL done_pulses: got %0d want 1", done_pulses);
        end
        if (busy !== 1'b0 || col_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_frame: got busy=%b valid=%b want 0 0", busy, col_valid);
        end
        for (int i = 0; i < got_data.size() && i < WINDOW; i++) begin
            exp_addr = (base_model + i) % NUM_ROWS;
            checks += 3;
            if (got_data[i] !== rom_mem[exp_addr]) begin
                errors++; $display("FAIL beat_data[%0d]: got %h want %h", i, got_data[i], rom_mem[exp_addr]);
            end
            if (got_idx[i] !== i) begin
                errors++; $display("FAIL beat_index[%0d]: got %0d want %0d", i, got_idx[i], i);
            end
            if (got_addr[i] !== exp_addr) begin
                errors++; $display("FAIL beat_addr[%0d]: got %0d want %0d", i, got_addr[i], exp_addr);
            end
        end
        if (scroll_final) base_model = (base_model + 1) % NUM_ROWS;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 6;
        if (rom_address !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_address); end
        if (col_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", col_data); end
        if (col_index !== '0) begin errors++; $display("FAIL reset_index: got %0d want 0", col_index); end
        if (col_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", col_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        rst_n = 1'b1;
        base_model = 0;
    endtask

    task automatic test_basic();
        run_frame(100, -1, -1, 1'b0, 1'b0);
        if (got_data.size() > 3) begin
            checks += 3;
            if (got_data[0] !== 57'h7) begin errors++; $display("FAIL first_beat: got %h want 7", got_data[0]); end
            if (got_idx[0] !== 0) begin errors++; $display("FAIL first_index: got %0d want 0", got_idx[0]); end
            if (got_data[3] !== 57'h1F8) begin errors++; $display("FAIL fourth_beat: got %h want 1f8", got_data[3]); end
        end
    endtask

    task automatic test_latency();
        int r;
        run_frame(100, -1, -1, 1'b0, 1'b0);
        checks++;
        if (got_addr.size() == 0 || got_addr[0] !== 0) begin
            errors++; $display("FAIL base_held: got %0d want 0", got_addr.size() ? got_addr[0] : -1);
        end
        for (int k = 1; k < rise_cyc.size(); k++) begin
            checks++;
            if (rise_cyc[k] - rise_cyc[k-1] !== 4) begin
                errors++; $display("FAIL beat_spacing[%0d]: got %0d want 4", k, rise_cyc[k] - rise_cyc[k-1]);
            end
        end
        foreach (chg_cyc[j]) begin
            r = -1;
            foreach (rise_cyc[k]) if (r < 0 && rise_cyc[k] > chg_cyc[j]) r = rise_cyc[k];
            checks++;
            if (r - chg_cyc[j] !== ROM_LAT + 1) begin
                errors++; $display("FAIL addr_to_valid[%0d]: got %0d want %0d", j, r - chg_cyc[j], ROM_LAT + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        run_frame(100, 2, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) run_frame(60, -1, -1, 1'($urandom_range(1)), 1'b1);
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (base_model != 120 && guard < 200) begin
            run_frame(100, -1, -1, 1'b1, 1'b0);
            guard++;
        end
        run_frame(75, -1, -1, 1'b1, 1'b0);
        if (got_addr.size() > 31) begin
            checks += 4;
            if (got_addr[0] !== 120) begin errors++; $display("FAIL wrap_first_addr: got %0d want 120", got_addr[0]); end
            if (got_addr[8] !== 128) begin errors++; $display("FAIL wrap_top_addr: got %0d want 128", got_addr[8]); end
            if (got_data[9] !== 57'h7) begin errors++; $display("FAIL wrap_beat9: got %h want 7", got_data[9]); end
            if (got_addr[31] !== 22) begin errors++; $display("FAIL wrap_last_addr: got %0d want 22", got_addr[31]); end
        end
        run_frame(100, -1, -1, 1'b0, 1'b0);
        checks++;
        if (got_addr.size() == 0 || got_addr[0] !== 121) begin
            errors++; $display("FAIL base_after_wrap: got %0d want 121", got_addr.size() ? got_addr[0] : -1);
        end
    endtask

    task automatic test_start_busy();
        run_frame(100, -1, 10, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int guard;
        col_ready = 1'b1;
        scroll_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (!(col_valid && col_index == 8'd4) && guard < 500) begin
            @(negedge clk); guard++;
        end
        checks++;
        if (guard >= 500) begin errors++; $display("FAIL reach_beat4: got timeout want beat 4"); end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 6;
        if (rom_address !== '0) begin errors++; $display("FAIL areset_addr: got %0d want 0", rom_address); end
        if (col_data !== '0) begin errors++; $display("FAIL areset_data: got %h want 0", col_data); end
        if (col_index !== '0) begin errors++; $display("FAIL areset_index: got %0d want 0", col_index); end
        if (col_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", col_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b want 0", frame_done); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        base_model = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL no_partial_done: got done=%b busy=%b want 0 0", frame_done, busy);
            end
        end
        run_frame(100, -1, -1, 1'b0, 1'b0);
        checks++;
        if (got_data.size() == 0 || got_data[0] !== 57'h7) begin
            errors++; $display("FAIL post_reset_first: got %h want 7", got_data.size() ? got_data[0] : '0);
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; scroll_en = 1'b0; col_ready = 1'b0;
        errors = 0; checks = 0; base_model = 0; done_pulses = 0;
        for (int i = 0; i < NUM_ROWS; i++) rom_mem[i] = ROW_WIDTH'({$urandom(), $urandom()});
        rom_mem[0] = 57'h7;
        rom_mem[3] = 57'h1F8;
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_start_busy();
        test_random_frames();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
